// File: rtl/keccak_state_splitter.sv
// Keccak state splitter: captures the two AES key seeds from the final state
// and streams the eight scratchpad-init blocks, one per handshake.
module keccak_state_splitter #(
   parameter int B            = 1600,
   parameter int W            = 128,
   parameter int NBLOCKS      = 8,
   parameter int BLOCK_OFFSET = 512
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_state_valid,
   input  logic [B-1:0] i_v_state,
   output logic         o_state_ready,
   output logic         o_key_valid,
   output logic [255:0] o_v_key0,
   output logic [255:0] o_v_key1,
   output logic         o_block_valid,
   output logic [W-1:0] o_v_block,
   output logic [2:0]   o_block_idx,
   input  logic         i_block_ready,
   output logic         o_done
);

   localparam int BUFW = NBLOCKS * W;
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;
   localparam logic [2:0] LAST_IDX = 3'(NBLOCKS - 1);

   logic [0:0]      state_q, state_d;
   logic [255:0]    key0_q, key0_d;
   logic [255:0]    key1_q, key1_d;
   logic            keyv_q, keyv_d;
   logic [BUFW-1:0] buf_q, buf_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            done_q, done_d;

   logic accept;
   logic take;
   logic unused_state_bits;

   // Bytes past the last block are dropped.
   assign unused_state_bits = ^i_v_state[B-1:BLOCK_OFFSET+BUFW];

   assign accept = i_state_valid && (state_q == S_IDLE);
   assign take   = i_block_ready && (state_q == S_STREAM);

   // Next-state logic for capture, streaming and the done pulse.
   always_comb begin
      state_d = state_q;
      key0_d  = key0_q;
      key1_d  = key1_q;
      keyv_d  = keyv_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (accept) begin
         key0_d  = i_v_state[255:0];
         key1_d  = i_v_state[511:256];
         keyv_d  = 1'b1;
         buf_d   = i_v_state[BLOCK_OFFSET +: BUFW];
         cnt_d   = 3'd0;
         state_d = S_STREAM;
      end else if (take) begin
         buf_d = buf_q >> W;
         if (cnt_q == LAST_IDX) begin
            cnt_d   = 3'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         key0_q  <= '0;
         key1_q  <= '0;
         keyv_q  <= 1'b0;
         buf_q   <= '0;
         cnt_q   <= 3'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key0_q  <= key0_d;
         key1_q  <= key1_d;
         keyv_q  <= keyv_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign o_state_ready = (state_q == S_IDLE);
   assign o_block_valid = (state_q == S_STREAM);
   assign o_key_valid   = keyv_q;
   assign o_v_key0      = key0_q;
   assign o_v_key1      = key1_q;
   assign o_v_block     = buf_q[W-1:0];
   assign o_block_idx   = cnt_q;
   assign o_done        = done_q;

endmodule
